// File: rtl/multicycle_main_fsm.sv
// Main control FSM for the multicycle RV32 core (lw/sw/R/I/jal/beq).
// Moore outputs per state; memory and branch strobes gated by mem_ready/zero.
module multicycle_main_fsm (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic       RegWrite,
    output logic [1:0] ALUOp,
    output logic [1:0] ImmSrc,
    output logic       illegal_op,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEMADR    = 4'd2,
        S_MEMREAD   = 4'd3,
        S_MEMWB     = 4'd4,
        S_MEMWRITE  = 4'd5,
        S_EXECUTER  = 4'd6,
        S_ALUWB     = 4'd7,
        S_EXECUTEI  = 4'd8,
        S_JAL       = 4'd9,
        S_BEQ       = 4'd10
    } state_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    state_t state_q;
    state_t state_d;

    logic is_lw;
    logic is_sw;
    logic is_r;
    logic is_i;
    logic is_jal;
    logic is_beq;

    assign is_lw  = (op == OP_LW);
    assign is_sw  = (op == OP_SW);
    assign is_r   = (op == OP_R);
    assign is_i   = (op == OP_I);
    assign is_jal = (op == OP_JAL);
    assign is_beq = (op == OP_BEQ);

    assign state = state_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = S_FETCH;
        PCWrite    = 1'b0;
        AdrSrc     = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        ResultSrc  = 2'b00;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        RegWrite   = 1'b0;
        ALUOp      = 2'b00;
        illegal_op = 1'b0;
        case (state_q)
            S_FETCH: begin
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                IRWrite   = mem_ready;
                PCWrite   = mem_ready;
                state_d   = mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                unique case (1'b1)
                    is_lw, is_sw: state_d = S_MEMADR;
                    is_r:         state_d = S_EXECUTER;
                    is_i:         state_d = S_EXECUTEI;
                    is_jal:       state_d = S_JAL;
                    is_beq:       state_d = S_BEQ;
                    default: begin
                        illegal_op = 1'b1;
                        state_d    = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                state_d = is_lw ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                AdrSrc  = 1'b1;
                state_d = mem_ready ? S_MEMWB : S_MEMREAD;
            end
            S_MEMWB: begin
                ResultSrc = 2'b01;
                RegWrite  = 1'b1;
            end
            S_MEMWRITE: begin
                // Strobe stays up across wait cycles until memory accepts it.
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
                state_d  = mem_ready ? S_FETCH : S_MEMWRITE;
            end
            S_EXECUTER: begin
                ALUSrcA = 2'b10;
                ALUOp   = 2'b10;
                state_d = S_ALUWB;
            end
            S_EXECUTEI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                ALUOp   = 2'b10;
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                RegWrite = 1'b1;
            end
            S_JAL: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b10;
                PCWrite = 1'b1;
                state_d = S_ALUWB;
            end
            S_BEQ: begin
                ALUSrcA = 2'b10;
                ALUOp   = 2'b01;
                PCWrite = zero;
            end
            default: state_d = S_FETCH;
        endcase
    end

    always_comb begin
        ImmSrc = 2'b00;
        unique case (1'b1)
            is_sw:   ImmSrc = 2'b01;
            is_beq:  ImmSrc = 2'b10;
            is_jal:  ImmSrc = 2'b11;
            default: ImmSrc = 2'b00;
        endcase
    end

endmodule

// File: tb/tb_multicycle_main_fsm.sv
// Directed bench for multicycle_main_fsm: walks each instruction class,
// memory waits, illegal opcode and asynchronous reset mid-instruction.
module tb_multicycle_main_fsm;

    logic       clk;
    logic       reset;
    logic [6:0] op;
    logic       zero;
    logic       mem_ready;
    logic       PCWrite;
    logic       AdrSrc;
    logic       MemWrite;
    logic       IRWrite;
    logic [1:0] ResultSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic       RegWrite;
    logic [1:0] ALUOp;
    logic [1:0] ImmSrc;
    logic       illegal_op;
    logic [3:0] state;

    int n_chk;
    int n_fail;

    multicycle_main_fsm dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .PCWrite    (PCWrite),
        .AdrSrc     (AdrSrc),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .ResultSrc  (ResultSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .RegWrite   (RegWrite),
        .ALUOp      (ALUOp),
        .ImmSrc     (ImmSrc),
        .illegal_op (illegal_op),
        .state      (state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_chk     = 0;
        n_fail    = 0;
        reset     = 1'b1;
        op        = 7'b0000000;
        zero      = 1'b0;
        mem_ready = 1'b1;
        #3;
        // reset: Fetch outputs with mem_ready applied
        chk("rst_state", 8'(state), 8'd0);
        chk("rst_pcw", 8'(PCWrite), 8'd1);
        chk("rst_irw", 8'(IRWrite), 8'd1);
        chk("rst_alub", 8'(ALUSrcB), 8'd2);
        chk("rst_res", 8'(ResultSrc), 8'd2);
        chk("rst_memw", 8'(MemWrite), 8'd0);
        chk("rst_regw", 8'(RegWrite), 8'd0);
        mem_ready = 1'b0;
        #1;
        chk("rst_pcw_nr", 8'(PCWrite), 8'd0);
        tick;
        chk("rst_hold", 8'(state), 8'd0);
        #4;
        reset = 1'b0;
        // Fetch stall while memory is not ready
        op = 7'b0000011;
        tick;
        chk("fetch_wait", 8'(state), 8'd0);
        chk("fetch_wait_irw", 8'(IRWrite), 8'd0);
        mem_ready = 1'b1;
        #1;
        chk("fetch_irw", 8'(IRWrite), 8'd1);
        chk("lw_imm", 8'(ImmSrc), 8'd0);
        // lw: 0,1,2,3,4,0
        tick;
        chk("lw_s1", 8'(state), 8'd1);
        chk("lw_dec_a", 8'(ALUSrcA), 8'd1);
        chk("lw_dec_b", 8'(ALUSrcB), 8'd1);
        chk("lw_dec_irw", 8'(IRWrite), 8'd0);
        tick;
        chk("lw_s2", 8'(state), 8'd2);
        chk("lw_adr_a", 8'(ALUSrcA), 8'd2);
        chk("lw_adr_regw", 8'(RegWrite), 8'd0);
        tick;
        chk("lw_s3", 8'(state), 8'd3);
        chk("lw_rd_adr", 8'(AdrSrc), 8'd1);
        chk("lw_rd_res", 8'(ResultSrc), 8'd0);
        chk("lw_rd_regw", 8'(RegWrite), 8'd0);
        tick;
        chk("lw_s4", 8'(state), 8'd4);
        chk("lw_wb_regw", 8'(RegWrite), 8'd1);
        chk("lw_wb_res", 8'(ResultSrc), 8'd1);
        tick;
        chk("lw_s0", 8'(state), 8'd0);
        chk("lw_end_regw", 8'(RegWrite), 8'd0);
        // sw with two wait cycles in MemWrite
        op = 7'b0100011;
        #1;
        chk("sw_imm", 8'(ImmSrc), 8'd1);
        tick;
        chk("sw_s1", 8'(state), 8'd1);
        tick;
        chk("sw_s2", 8'(state), 8'd2);
        mem_ready = 1'b0;
        tick;
        chk("sw_s5a", 8'(state), 8'd5);
        chk("sw_mw1", 8'(MemWrite), 8'd1);
        chk("sw_adr", 8'(AdrSrc), 8'd1);
        tick;
        chk("sw_s5b", 8'(state), 8'd5);
        chk("sw_mw2", 8'(MemWrite), 8'd1);
        mem_ready = 1'b1;
        #1;
        chk("sw_mw3", 8'(MemWrite), 8'd1);
        tick;
        chk("sw_s0", 8'(state), 8'd0);
        chk("sw_end_mw", 8'(MemWrite), 8'd0);
        // beq taken
        op   = 7'b1100011;
        zero = 1'b1;
        #1;
        chk("beq_imm", 8'(ImmSrc), 8'd2);
        tick;
        tick;
        chk("beq_s10", 8'(state), 8'd10);
        chk("beq_pcw_t", 8'(PCWrite), 8'd1);
        chk("beq_aluop", 8'(ALUOp), 8'd1);
        chk("beq_a", 8'(ALUSrcA), 8'd2);
        tick;
        chk("beq_s0", 8'(state), 8'd0);
        // beq not taken
        zero = 1'b0;
        tick;
        tick;
        chk("beq2_s10", 8'(state), 8'd10);
        chk("beq_pcw_nt", 8'(PCWrite), 8'd0);
        tick;
        chk("beq2_s0", 8'(state), 8'd0);
        // jal: 0,1,9,7,0
        op = 7'b1101111;
        #1;
        chk("jal_imm", 8'(ImmSrc), 8'd3);
        tick;
        chk("jal_s1", 8'(state), 8'd1);
        tick;
        chk("jal_s9", 8'(state), 8'd9);
        chk("jal_pcw", 8'(PCWrite), 8'd1);
        chk("jal_a", 8'(ALUSrcA), 8'd1);
        chk("jal_b", 8'(ALUSrcB), 8'd2);
        tick;
        chk("jal_s7", 8'(state), 8'd7);
        chk("jal_regw", 8'(RegWrite), 8'd1);
        chk("jal_s7_pcw", 8'(PCWrite), 8'd0);
        tick;
        chk("jal_s0", 8'(state), 8'd0);
        // illegal opcode
        op = 7'b1110011;
        #1;
        chk("ill_fetch", 8'(illegal_op), 8'd0);
        tick;
        chk("ill_s1", 8'(state), 8'd1);
        chk("ill_pulse", 8'(illegal_op), 8'd1);
        tick;
        chk("ill_s0", 8'(state), 8'd0);
        chk("ill_clear", 8'(illegal_op), 8'd0);
        // I-type: 0,1,8,7,0
        op = 7'b0010011;
        tick;
        tick;
        chk("i_s8", 8'(state), 8'd8);
        chk("i_aluop", 8'(ALUOp), 8'd2);
        chk("i_b", 8'(ALUSrcB), 8'd1);
        tick;
        chk("i_s7", 8'(state), 8'd7);
        tick;
        chk("i_s0", 8'(state), 8'd0);
        // R-type, reset asynchronously mid-ExecuteR
        op = 7'b0110011;
        tick;
        tick;
        chk("r_s6", 8'(state), 8'd6);
        chk("r_aluop", 8'(ALUOp), 8'd2);
        chk("r_b", 8'(ALUSrcB), 8'd0);
        #2;
        reset = 1'b1;
        #1;
        chk("async_state", 8'(state), 8'd0);
        chk("async_regw", 8'(RegWrite), 8'd0);
        tick;
        chk("async_hold", 8'(state), 8'd0);
        #2;
        reset = 1'b0;
        tick;
        chk("post_rst_s1", 8'(state), 8'd1);
        tick;
        chk("post_rst_s6", 8'(state), 8'd6);
        tick;
        chk("post_rst_s7", 8'(state), 8'd7);
        chk("post_rst_regw", 8'(RegWrite), 8'd1);
        tick;
        chk("post_rst_s0", 8'(state), 8'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/multicycle_main_fsm.md
MULTICYCLE_MAIN_FSM -- requirements
Module: multicycle_main_fsm

Interface
REQ-001 SHALL provide: clk  input  1  single rising-edge clock for all state.
REQ-002 SHALL provide: reset  input  1  asynchronous, active-high reset.
REQ-003 SHALL provide: op  input  7  opcode field of the registered instruction, bits [6:0].
REQ-004 SHALL provide: zero  input  1  ALU zero flag.
REQ-005 SHALL provide: mem_ready  input  1  unified memory access complete this cycle.
REQ-006 SHALL provide: PCWrite  output  1  PC register load enable.
REQ-007 SHALL provide: AdrSrc  output  1  memory address select: 0 = PC, 1 = ALU result register.
REQ-008 SHALL provide: MemWrite  output  1  data memory write strobe.
REQ-009 SHALL provide: IRWrite  output  1  instruction register and old-PC register load enable.
REQ-010 SHALL provide: ResultSrc  output  2  result select: 00 = ALUOut, 01 = Data, 10 = ALUResult.
REQ-011 SHALL provide: ALUSrcA  output  2  ALU A select: 00 = PC, 01 = OldPC, 10 = rs1 data.
REQ-012 SHALL provide: ALUSrcB  output  2  ALU B select: 00 = rs2 data, 01 = ImmExt, 10 = constant 4.
REQ-013 SHALL provide: RegWrite  output  1  register file write enable.
REQ-014 SHALL provide: ALUOp  output  2  class code to the ALU decoder: 00 = add, 01 = sub/branch, 10 = funct-decoded.
REQ-015 SHALL provide: ImmSrc  output  2  immediate format: 00 = I, 01 = S, 10 = B, 11 = J.
REQ-016 SHALL provide: illegal_op  output  1  one-cycle pulse for an unsupported opcode.
REQ-017 SHALL provide: state  output  4  current state encoding, for debug.

Function
REQ-018 SHALL encode the states as Fetch=0, Decode=1, MemAdr=2, MemRead=3, MemWB=4, MemWrite=5, ExecuteR=6, ALUWB=7, ExecuteI=8, JAL=9, BEQ=10; codes 11-15 SHALL transition to Fetch.
REQ-019 SHALL drive all control outputs as a Moore function of state, except PCWrite, IRWrite and MemWrite, which are also gated by mem_ready/zero as stated below; unlisted outputs SHALL be 0.
REQ-020 Fetch SHALL drive AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10, and IRWrite=PCWrite=mem_ready; it SHALL stay in Fetch while mem_ready=0 and go to Decode otherwise.
REQ-021 Decode SHALL drive ALUSrcA=01, ALUSrcB=01, ALUOp=00 and SHALL go to: MemAdr for op 0000011 or 0100011; ExecuteR for 0110011; ExecuteI for 0010011; JAL for 1101111; BEQ for 1100011.
REQ-022 Decode with any other op SHALL pulse illegal_op=1 for that cycle and return to Fetch.
REQ-023 MemAdr SHALL drive ALUSrcA=10, ALUSrcB=01, ALUOp=00 and SHALL go to MemRead if op=0000011, else to MemWrite.
REQ-024 MemRead SHALL drive AdrSrc=1, ResultSrc=00, holding while mem_ready=0 and going to MemWB when mem_ready=1.
REQ-025 MemWB SHALL drive ResultSrc=01, RegWrite=1, then go to Fetch.
REQ-026 MemWrite SHALL drive AdrSrc=1, ResultSrc=00, MemWrite=1 held every cycle until mem_ready=1, then go to Fetch.
REQ-027 ExecuteR SHALL drive ALUSrcA=10, ALUSrcB=00, ALUOp=10; ExecuteI SHALL drive ALUSrcA=10, ALUSrcB=01, ALUOp=10; both SHALL go to ALUWB.
REQ-028 ALUWB SHALL drive ResultSrc=00, RegWrite=1, then go to Fetch.
REQ-029 JAL SHALL drive ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCWrite=1, then go to ALUWB.
REQ-030 BEQ SHALL drive ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, PCWrite=zero, then go to Fetch.
REQ-031 ImmSrc SHALL be combinational from op in every state: 0000011/0010011 → 00; 0100011 → 01; 1100011 → 10; 1101111 → 11; other → 00.
REQ-032 Instruction latency SHALL be, excluding memory waits: lw 5, sw 4, R/I 4, jal 4, beq 3 cycles.

Reset
REQ-033 Assertion of reset SHALL force state=Fetch asynchronously, including in the middle of an instruction.
REQ-034 During reset, all outputs SHALL be the Fetch values with mem_ready applied; no MemWrite or RegWrite SHALL be asserted.
REQ-035 The first Fetch SHALL begin on the first clk rising edge after reset deasserts.

Verification
REQ-036 The bench SHALL cover: reset, then op=0000011 with mem_ready=1 → states 0,1,2,3,4,0; RegWrite=1 only in state 4; ResultSrc=01.
REQ-037 The bench SHALL cover: op=0100011, with mem_ready low for 2 cycles in MemWrite → MemWrite=1 for 3 cycles, then Fetch.
REQ-038 The bench SHALL cover: op=1100011 with zero=1 → PCWrite=1 in BEQ and ALUOp=01; with zero=0 → PCWrite=0.
REQ-039 The bench SHALL cover: op=1101111 → states 0,1,9,7,0; PCWrite=1 in state 9 and ImmSrc=11.
REQ-040 The bench SHALL cover: op=1110011 → illegal_op pulses 1 cycle in Decode and the FSM returns to Fetch.
REQ-041 The bench SHALL cover: reset asserted mid-ExecuteR, asynchronous to clk → state=0 immediately and RegWrite=0.
